uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, companion of uart_tx, sitting between the board RX pin
// and the LIF host-command logic. The asynchronous rx line is brought into
// the clock domain through a two-flop synchroniser. The start bit is
// re-checked at its centre, and every data and stop bit is sampled at
// mid-period. Received bytes are held in data_out until the consumer
// acknowledges them.
//
// Parameters:
//   CLOCK_FREQ  board clock in Hz
//   BAUD_RATE   serial baud rate (CLOCK_FREQ/BAUD_RATE must be >= 8)
//
// Ports:
//   clk         sole clock
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idles high
//   data_out    last received byte
//   data_valid  data_out holds a byte that has not yet been acknowledged
//   data_ack    consumer takes the byte; data_valid clears on the next cycle
//   frame_err   one-cycle pulse when the stop bit samples low
//   overrun     one-cycle pulse when a new byte replaces an unacknowledged one
//   busy        high whenever the receiver is not idle
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each sample point takes a 2-of-3
//                        majority over the last three synchronised samples,
//                        so a single-cycle glitch at the centre is rejected.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BAUD_TICK = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF      = BAUD_TICK / 2;
    localparam int CW        = $clog2(BAUD_TICK);

    // The start bit is judged at its centre; from then on, every sample
    // lands one full bit period later, which is again a bit centre.
    localparam logic [CW-1:0] START_TGT = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_TGT   = CW'(BAUD_TICK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bitIdx_q;
    logic [7:0]      shift_q;
    logic [7:0]      dataOut_q;
    logic            dataValid_q;
    logic            frameErr_q;
    logic            overrun_q;
    logic            busy_q;

    logic            rxMeta_q;
    logic            rxSync_q;
    logic            sampleBit;

    // Two-flop synchroniser. Both stages reset to the idle level so that
    // reset never looks like a start bit by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] voteHist_q;

    // History of the two previous synchronised samples. The counter steps by
    // one every cycle inside a bit, so at the target count these hold the
    // values seen at target-2 and target-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            voteHist_q <= 2'b11;
        end else begin
            voteHist_q <= {voteHist_q[0], rxSync_q};
        end
    end

    assign sampleBit = (voteHist_q[1] & voteHist_q[0]) |
                       (voteHist_q[1] & rxSync_q)      |
                       (voteHist_q[0] & rxSync_q);
`else
    assign sampleBit = rxSync_q;
`endif

    // Receive state machine. All outputs are registered here. cnt_q is
    // cleared on every state change so that each state measures its own
    // interval from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= 3'd0;
            shift_q     <= 8'h00;
            dataOut_q   <= 8'h00;
            dataValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;

            // An acknowledge only matters while a byte is held. A byte load
            // later in this block overrides the clear, so a load coincident
            // with an acknowledge leaves data_valid set.
            if (data_ack && dataValid_q) begin
                dataValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxSync_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == START_TGT) begin
                        cnt_q <= '0;
                        if (!sampleBit) begin
                            state_q  <= DATA;
                            bitIdx_q <= 3'd0;
                        end else begin
                            // A low pulse shorter than half a bit is noise.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_TGT) begin
                        cnt_q   <= '0;
                        shift_q <= {sampleBit, shift_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == BIT_TGT) begin
                        cnt_q <= '0;
                        if (sampleBit) begin
                            dataOut_q   <= shift_q;
                            dataValid_q <= 1'b1;
                            if (dataValid_q && !data_ack) begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Byte is dropped; the held byte is left intact.
                            frameErr_q <= 1'b1;
                            state_q    <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    // A line held low (break) must return high before a new
                    // start bit is accepted.
                    cnt_q <= '0;
                    if (rxSync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed self-checking bench for uart_rx at default parameters
// (104 clocks per bit, centre at 52). Frames are driven bit by bit on rx,
// and a negedge monitor records pulse counts, widths and timing of the
// DUT outputs for the scenario tasks to compare against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BT   = 104;
    localparam int HALF = 52;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cycleCnt = 0;
    int frameStart = 0;

    int riseCount = 0;
    int riseCycle = 0;
    int validRun = 0;
    int lastValidWidth = 0;
    int validFallCount = 0;
    int feCount = 0;
    int feRun = 0;
    int feMaxWidth = 0;
    int ovCount = 0;
    int ovRun = 0;
    int ovMaxWidth = 0;
    int busyRiseCount = 0;
    logic prevValid = 1'b0;
    logic prevBusy = 1'b0;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // 100 MHz nominal clock; only the cycle count matters.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid && !prevValid) begin
            riseCount++;
            riseCycle = cycleCnt;
        end
        if (data_valid) begin
            validRun++;
        end else if (prevValid) begin
            lastValidWidth = validRun;
            validRun = 0;
            validFallCount++;
        end
        prevValid = data_valid;

        if (frame_err) begin
            if (feRun == 0) feCount++;
            feRun++;
            if (feRun > feMaxWidth) feMaxWidth = feRun;
        end else begin
            feRun = 0;
        end

        if (overrun) begin
            if (ovRun == 0) ovCount++;
            ovRun++;
            if (ovRun > ovMaxWidth) ovMaxWidth = ovRun;
        end else begin
            ovRun = 0;
        end

        if (busy && !prevBusy) busyRiseCount++;
        prevBusy = busy;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. ackOffset < 0: no acknowledge; otherwise data_ack
    // is sampled high ackOffset clocks after the edge that loads the byte.
    // glitchBit3 puts a one-clock high pulse exactly on the bit-3 centre.
    task automatic applyStimulus(input logic [7:0] data, input logic stopVal,
                                 input int ackOffset, input bit glitchBit3);
        waitEdges(1);
        rx = 1'b0;
        frameStart = cycleCnt;
        waitEdges(BT);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (glitchBit3 && i == 3) begin
                waitEdges(HALF);
                rx = 1'b1;
                waitEdges(1);
                rx = data[i];
                waitEdges(BT - HALF - 1);
            end else begin
                waitEdges(BT);
            end
        end
        rx = stopVal;
        if (ackOffset >= 0) begin
            waitEdges(HALF + 2 + ackOffset);
            data_ack = 1'b1;
            waitEdges(1);
            data_ack = 1'b0;
            waitEdges(BT - HALF - 3 - ackOffset);
        end else begin
            waitEdges(BT);
        end
    endtask

    task automatic clearValid();
        data_ack = 1'b1;
        waitEdges(1);
        data_ack = 1'b0;
        waitEdges(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        data_ack = 1'b0;
        waitEdges(4);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data_out got %h want 00", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data_valid got %b want 0", data_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_err got %b want 0", frame_err);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overrun got %b want 0", overrun);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
        rst = 1'b0;
        waitEdges(3);
    endtask

    task automatic test_receive();
        int rise0 = riseCount;
        int fe0 = feCount;
        int ov0 = ovCount;
        int latency;
        applyStimulus(8'hA5, 1'b1, 10, 1'b0);
        waitEdges(5);
        latency = riseCycle - frameStart;
        checks++;
        if (riseCount - rise0 !== 1) begin
            errors++;
            $display("[TB] FAIL a5_valid_rises got %0d want 1", riseCount - rise0);
        end
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL a5_data got %h want a5", data_out);
        end
        checks++;
        if (latency < 990 || latency > 992) begin
            errors++;
            $display("[TB] FAIL a5_latency got %0d want 991+-1", latency);
        end
        checks++;
        if (lastValidWidth !== 10) begin
            errors++;
            $display("[TB] FAIL a5_valid_width got %0d want 10", lastValidWidth);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL a5_valid_after_ack got %b want 0", data_valid);
        end
        checks++;
        if (feCount - fe0 !== 0 || ovCount - ov0 !== 0) begin
            errors++;
            $display("[TB] FAIL a5_no_errors got fe=%0d ov=%0d want 0 0",
                     feCount - fe0, ovCount - ov0);
        end
    endtask

    task automatic test_false_start();
        int rise0 = riseCount;
        int busy0 = busyRiseCount;
        waitEdges(1);
        rx = 1'b0;
        waitEdges(20);
        rx = 1'b1;
        waitEdges(BT);
        checks++;
        if (busyRiseCount - busy0 !== 1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_pulse got %0d want 1", busyRiseCount - busy0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_back_idle got busy=%b want 0", busy);
        end
        checks++;
        if (riseCount - rise0 !== 0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_no_valid got rises=%0d valid=%b want 0 0",
                     riseCount - rise0, data_valid);
        end
    endtask

    task automatic test_frame_error();
        int fe0 = feCount;
        int rise0 = riseCount;
        feMaxWidth = 0;
        applyStimulus(8'h3C, 1'b0, -1, 1'b0);
        waitEdges(2 * BT);
        checks++;
        if (feCount - fe0 !== 1) begin
            errors++;
            $display("[TB] FAIL ferr_count got %0d want 1", feCount - fe0);
        end
        checks++;
        if (feMaxWidth !== 1) begin
            errors++;
            $display("[TB] FAIL ferr_width got %0d want 1", feMaxWidth);
        end
        checks++;
        if (data_valid !== 1'b0 || riseCount - rise0 !== 0) begin
            errors++;
            $display("[TB] FAIL ferr_no_valid got valid=%b rises=%0d want 0 0",
                     data_valid, riseCount - rise0);
        end
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL ferr_data_kept got %h want a5", data_out);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ferr_busy_while_low got %b want 1", busy);
        end
        rx = 1'b1;
        waitEdges(6);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ferr_busy_after_high got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int ov0 = ovCount;
        int fall0;
        ovMaxWidth = 0;
        applyStimulus(8'h11, 1'b1, -1, 1'b0);
        applyStimulus(8'h22, 1'b1, -1, 1'b0);
        waitEdges(3);
        checks++;
        if (ovCount - ov0 !== 1) begin
            errors++;
            $display("[TB] FAIL ovr_count got %0d want 1", ovCount - ov0);
        end
        checks++;
        if (ovMaxWidth !== 1) begin
            errors++;
            $display("[TB] FAIL ovr_width got %0d want 1", ovMaxWidth);
        end
        checks++;
        if (data_out !== 8'h22 || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_data got %h valid=%b want 22 1", data_out, data_valid);
        end
        clearValid();

        ov0 = ovCount;
        fall0 = validFallCount;
        applyStimulus(8'h11, 1'b1, -1, 1'b0);
        applyStimulus(8'h22, 1'b1, 0, 1'b0);
        waitEdges(3);
        checks++;
        if (ovCount - ov0 !== 0) begin
            errors++;
            $display("[TB] FAIL ackload_no_overrun got %0d want 0", ovCount - ov0);
        end
        checks++;
        if (data_valid !== 1'b1 || validFallCount - fall0 !== 0) begin
            errors++;
            $display("[TB] FAIL ackload_valid_held got valid=%b falls=%0d want 1 0",
                     data_valid, validFallCount - fall0);
        end
        checks++;
        if (data_out !== 8'h22) begin
            errors++;
            $display("[TB] FAIL ackload_data got %h want 22", data_out);
        end
        clearValid();
    endtask

    task automatic test_ack_ignored();
        data_ack = 1'b1;
        waitEdges(3);
        data_ack = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ack_valid got %b want 0", data_valid);
        end
        applyStimulus(8'h96, 1'b1, -1, 1'b0);
        waitEdges(3);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h96) begin
            errors++;
            $display("[TB] FAIL idle_ack_then_rx got %h valid=%b want 96 1",
                     data_out, data_valid);
        end
    endtask

    task automatic test_reset_midframe();
        // 0xFF frame cut during bit 4, while a byte is still held.
        waitEdges(1);
        rx = 1'b0;
        waitEdges(BT);
        rx = 1'b1;
        waitEdges(4 * BT + HALF);
        rst = 1'b1;
        waitEdges(3);
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_data got %h valid=%b want 00 0", data_out, data_valid);
        end
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_flags got busy=%b fe=%b ov=%b want 0 0 0",
                     busy, frame_err, overrun);
        end
        rst = 1'b0;
        waitEdges(2 * BT);
        applyStimulus(8'h5A, 1'b1, -1, 1'b0);
        waitEdges(3);
        checks++;
        if (data_out !== 8'h5A || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_next_byte got %h valid=%b want 5a 1",
                     data_out, data_valid);
        end
        clearValid();
    endtask

    task automatic test_glitch_vote();
        logic [7:0] expected;
`ifdef UART_RX_MAJORITY_EN
        expected = 8'h00;
`else
        expected = 8'h08;
`endif
        applyStimulus(8'h00, 1'b1, -1, 1'b1);
        waitEdges(3);
        checks++;
        if (data_out !== expected || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bit3_glitch got %h valid=%b want %h 1",
                     data_out, data_valid, expected);
        end
        clearValid();
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        data_ack = 1'b0;
        test_reset();
        test_receive();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_ack_ignored();
        test_reset_midframe();
        test_glitch_vote();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
